// File: rtl/rx_frame_controller_if.sv
// rx_frame_controller_if
// ----------------------
// Bundles the serial input and the shift-register control/status outputs of
// the ECE272 receive frame controller.
//
// Signals:
//   rx_line      serial line toward the controller (idle high, LSB first)
//   shift_en     one-cycle shift strobe for the 12-bit shift register
//   shift_bit    data bit presented with shift_en
//   shift_dump   one-cycle ShiftDump strobe (word -> parallel output)
//   frame_valid  one-cycle pulse the cycle after shift_dump
//   frame_error  one-cycle pulse on a bad stop bit (or parity)
//   busy         high whenever the controller is not idle
//   frame_count  running count of good frames (wraps)
//
// Modports:
//   master  the frame controller (drives the control/status outputs)
//   slave   the line driver / shift-register side
interface rx_frame_controller_if #(
    parameter int CNT_W = 8
);
    logic             rx_line;
    logic             shift_en;
    logic             shift_bit;
    logic             shift_dump;
    logic             frame_valid;
    logic             frame_error;
    logic             busy;
    logic [CNT_W-1:0] frame_count;

    modport master (
        input  rx_line,
        output shift_en,
        output shift_bit,
        output shift_dump,
        output frame_valid,
        output frame_error,
        output busy,
        output frame_count
    );

    modport slave (
        output rx_line,
        input  shift_en,
        input  shift_bit,
        input  shift_dump,
        input  frame_valid,
        input  frame_error,
        input  busy,
        input  frame_count
    );
endinterface

// File: rtl/rx_frame_controller.sv
// rx_frame_controller
// -------------------
// Frame sequencer for the 12-bit serial receive shift register. Detects the
// start bit on the asynchronous serial line, strobes shift_en at the middle
// of every data bit, checks the stop bit, then issues shift_dump followed by
// frame_valid. The shift register itself holds no timing logic.
//
// Optional build macro: PARITY_CHECK_EN
//   When defined, an even-parity bit is expected between the last data bit
//   and the stop bit; a parity mismatch raises frame_error and suppresses
//   shift_dump.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    rx_frame_controller_if.master (rx_line in; shift_en, shift_bit,
//          shift_dump, frame_valid, frame_error, busy, frame_count out)
module rx_frame_controller #(
    parameter int DATA_BITS    = 12,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    rx_frame_controller_if.master  bus
);

    localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef PARITY_CHECK_EN
    localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_DUMP      = 3'd5;
    localparam logic [2:0] ST_VALID     = 3'd6;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never fabricates a start edge.
    logic rx_meta_q;
    logic rx_s_q;

    logic [2:0]       state_q,       state_d;
    logic [TMR_W-1:0] timer_q,       timer_d;
    logic [BIT_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic             shift_en_q,    shift_en_d;
    logic             shift_bit_q,   shift_bit_d;
    logic             shift_dump_q,  shift_dump_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             busy_q,        busy_d;
`ifdef PARITY_CHECK_EN
    logic             parity_q,      parity_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_line;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_cnt_d     = bit_cnt_q;
        frame_count_d = frame_count_q;
        shift_en_d    = 1'b0;
        shift_bit_d   = shift_bit_q;
        shift_dump_d  = 1'b0;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end

            // Wait half a bit so every later sample lands mid-bit; a line
            // that is high again by then was a glitch.
            ST_START: begin
                if (timer_q == TMR_HALF_LAST) begin
                    timer_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        parity_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (timer_q == TMR_LAST) begin
                    timer_d     = '0;
                    shift_en_d  = 1'b1;
                    shift_bit_d = rx_s_q;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
                    parity_d    = parity_q ^ rx_s_q;
`endif
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

`ifdef PARITY_CHECK_EN
            // Even parity: data XOR parity bit must be zero.
            ST_PARITY: begin
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (parity_q ^ rx_s_q) begin
                        frame_error_d = 1'b1;
                        state_d       = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_DUMP;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_DUMP: begin
                shift_dump_d = 1'b1;
                state_d      = ST_VALID;
            end

            ST_VALID: begin
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 1'b1;
                state_d       = ST_IDLE;
            end

            // A line stuck low after a bad frame must not look like a new
            // start bit; wait for it to return high first.
            ST_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            frame_count_q <= '0;
            shift_en_q    <= 1'b0;
            shift_bit_q   <= 1'b0;
            shift_dump_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_count_q <= frame_count_d;
            shift_en_q    <= shift_en_d;
            shift_bit_q   <= shift_bit_d;
            shift_dump_q  <= shift_dump_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
`ifdef PARITY_CHECK_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign bus.shift_en    = shift_en_q;
    assign bus.shift_bit   = shift_bit_q;
    assign bus.shift_dump  = shift_dump_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb_rx_frame_controller
// ----------------------
// Drives serial frames onto rx_line at 16 clocks per bit and checks the
// controller's strobes against a frame-level model: the word reassembled
// from shift_bit must equal the word sent, a frame is good exactly when its
// stop bit (and parity, if built in) is right, and frame_count advances by
// one per good frame modulo 256.
module tb_rx_frame_controller;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rx_frame_controller_if #(.CNT_W(8)) bus ();

    rx_frame_controller #(
        .DATA_BITS    (12),
        .CLKS_PER_BIT (CPB),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- output monitor (sampled on the falling edge) -------
    int          cyc       = 0;
    int          n_shift   = 0;
    int          n_dump    = 0;
    int          n_valid   = 0;
    int          n_error   = 0;
    int          n_wrap    = 0;
    int          dump_cyc  = 0;
    int          valid_cyc = 0;
    logic [11:0] cap       = '0;
    logic [7:0]  prev_fc   = '0;
    int          shift_times[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.shift_en === 1'b1) begin
            n_shift = n_shift + 1;
            cap     = {bus.shift_bit, cap[11:1]};
            shift_times.push_back(cyc);
        end
        if (bus.shift_dump === 1'b1) begin
            n_dump   = n_dump + 1;
            dump_cyc = cyc;
        end
        if (bus.frame_valid === 1'b1) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (bus.frame_error === 1'b1) n_error = n_error + 1;
        if (prev_fc == 8'hFF && bus.frame_count == 8'h00) n_wrap = n_wrap + 1;
        prev_fc = bus.frame_count;
    end

    // ---------------- helpers --------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, 12 data bits LSB first, optional parity bit, stop bit.
    // The line is left at the stop-bit level; the caller decides what next.
    task automatic send_frame(input logic [11:0] w, input logic par, input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 12; i++) drive_bit(w[i]);
`ifdef PARITY_CHECK_EN
        drive_bit(par);
`else
        if (par === 1'bx) bus.rx_line = 1'b1;  // parity bit unused in this build
`endif
        drive_bit(stp);
    endtask

    // ---------------- directed / randomized sequence ---------------------
    logic [7:0]  exp_fc;
    int          b_shift, b_dump, b_valid, b_error, b_wrap, b_times;
    int          busy_cnt, bad_iv;
    logic [11:0] w;
    logic        stp, par, par_ok, good;

    task automatic snap();
        b_shift = n_shift;
        b_dump  = n_dump;
        b_valid = n_valid;
        b_error = n_error;
        b_wrap  = n_wrap;
        b_times = shift_times.size();
    endtask

    initial begin
        exp_fc      = '0;
        reset       = 1'b1;
        bus.rx_line = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_frame_count", 32'(bus.frame_count), 32'd0);
        check("rst_pulses",      32'({bus.shift_en, bus.shift_dump, bus.frame_valid, bus.frame_error}), 32'd0);
        check("rst_shift_bit",   32'(bus.shift_bit),   32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Reset held two cycles mid-DATA, after 5 shift_en pulses.
        // Bits 4..11 of 0xFF0 are high, so the remainder of the frame
        // carries no falling edge that could restart reception.
        snap();
        fork
            send_frame(12'hFF0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 400 && (n_shift - b_shift) < 5; i++) @(negedge clk);
                check("midrst_shifts_seen", 32'(n_shift - b_shift), 32'd5);
                reset = 1'b1;
                @(negedge clk);
                check("midrst_busy_in_reset", 32'(bus.busy), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("midrst_busy_after", 32'(bus.busy), 32'd0);
                check("midrst_frame_count", 32'(bus.frame_count), 32'd0);
            end
        join
        repeat (20) @(negedge clk);
        check("midrst_no_dump",  32'(n_dump - b_dump),   32'd0);
        check("midrst_no_valid", 32'(n_valid - b_valid), 32'd0);
        check("midrst_no_error", 32'(n_error - b_error), 32'd0);
        check("midrst_idle",     32'(bus.busy),          32'd0);
        $display("txn reset_mid_frame shifts_before_reset=%0d", n_shift - b_shift);

        // Clean frame 0xA5C
        snap();
        send_frame(12'hA5C, ^12'hA5C, 1'b1);
        repeat (20) @(negedge clk);
        exp_fc = exp_fc + 8'd1;
        check("a5c_shifts", 32'(n_shift - b_shift), 32'd12);
        check("a5c_word",   32'(cap),               32'hA5C);
        bad_iv = 0;
        for (int i = b_times + 1; i < shift_times.size(); i++)
            if (shift_times[i] - shift_times[i-1] != CPB) bad_iv++;
        check("a5c_bit_spacing", 32'(bad_iv), 32'd0);
        check("a5c_dump",   32'(n_dump - b_dump),   32'd1);
        check("a5c_valid",  32'(n_valid - b_valid), 32'd1);
        check("a5c_valid_after_dump", 32'(valid_cyc - dump_cyc), 32'd1);
        check("a5c_error",  32'(n_error - b_error), 32'd0);
        check("a5c_frame_count", 32'(bus.frame_count), 32'(exp_fc));
        $display("txn frame word=0x%03h stop=1 captured=0x%03h count=%0d", 12'hA5C, cap, bus.frame_count);

        // Glitch: line low 3 cycles, then high again
        snap();
        busy_cnt = 0;
        bus.rx_line = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx_line = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check("glitch_shifts",     32'(n_shift - b_shift), 32'd0);
        check("glitch_busy_short", 32'(busy_cnt <= 10),    32'd1);
        check("glitch_no_error",   32'(n_error - b_error), 32'd0);
        check("glitch_idle",       32'(bus.busy),          32'd0);
        $display("txn glitch busy_cycles=%0d", busy_cnt);

        // Frame 0x000 with a bad stop bit, line held low 40 more cycles
        snap();
        send_frame(12'h000, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("badstop_error",      32'(n_error - b_error), 32'd1);
        check("badstop_busy_held",  32'(bus.busy),          32'd1);
        bus.rx_line = 1'b1;
        repeat (8) @(negedge clk);
        check("badstop_busy_release", 32'(bus.busy),        32'd0);
        check("badstop_no_dump",    32'(n_dump - b_dump),   32'd0);
        check("badstop_frame_count", 32'(bus.frame_count),  32'(exp_fc));
        $display("txn frame word=0x000 stop=0 errors=%0d", n_error - b_error);

`ifdef PARITY_CHECK_EN
        // Parity: 0x001 needs parity bit 1 for even parity
        snap();
        send_frame(12'h001, 1'b0, 1'b1);
        bus.rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("par_bad_error", 32'(n_error - b_error), 32'd1);
        check("par_bad_dump",  32'(n_dump - b_dump),   32'd0);
        $display("txn parity word=0x001 par=0 errors=%0d", n_error - b_error);
        snap();
        send_frame(12'h001, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        exp_fc = exp_fc + 8'd1;
        check("par_good_dump",  32'(n_dump - b_dump),   32'd1);
        check("par_good_valid_after_dump", 32'(valid_cyc - dump_cyc), 32'd1);
        check("par_good_error", 32'(n_error - b_error), 32'd0);
        $display("txn parity word=0x001 par=1 dumps=%0d", n_dump - b_dump);
`endif

        // Randomized frames with occasional bad stop (and parity) bits
        for (int f = 0; f < 12; f++) begin
            w      = 12'($urandom);
            stp    = ($urandom_range(0, 3) != 0);
`ifdef PARITY_CHECK_EN
            par_ok = ($urandom_range(0, 3) != 0);
`else
            par_ok = 1'b1;
`endif
            par    = (^w) ^ ~par_ok;
            good   = stp & par_ok;
            snap();
            send_frame(w, par, stp);
            repeat (20) @(negedge clk);
            bus.rx_line = 1'b1;
            repeat (40) @(negedge clk);
            if (good) exp_fc = exp_fc + 8'd1;
            check("rand_shifts", 32'(n_shift - b_shift), 32'd12);
            check("rand_word",   32'(cap),               32'(w));
            check("rand_dump",   32'(n_dump - b_dump),   32'(good));
            check("rand_valid",  32'(n_valid - b_valid), 32'(good));
            check("rand_error",  32'(n_error - b_error), 32'(!good));
            check("rand_frame_count", 32'(bus.frame_count), 32'(exp_fc));
            $display("txn rand word=0x%03h stop=%0b par_ok=%0b captured=0x%03h count=%0d",
                     w, stp, par_ok, cap, bus.frame_count);
        end

        // 256 back-to-back good frames: frame_count must wrap exactly once
        snap();
        for (int f = 0; f < 256; f++) begin
            w = 12'($urandom);
            send_frame(w, ^w, 1'b1);
            $display("txn b2b idx=%0d word=0x%03h", f, w);
        end
        repeat (30) @(negedge clk);
        check("b2b_valids",      32'(n_valid - b_valid), 32'd256);
        check("b2b_no_error",    32'(n_error - b_error), 32'd0);
        check("b2b_wraps",       32'(n_wrap - b_wrap),   32'd1);
        check("b2b_frame_count", 32'(bus.frame_count),   32'(exp_fc));
        check("b2b_last_word",   32'(cap),               32'(w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
